// File: rtl/uart_byte_rx.sv
// uart_byte_rx
// Asynchronous serial receiver: 8 data bits, LSB first, optional parity,
// one stop bit. Turns the raw rx pin into single-cycle byte strobes.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 4)
//   PARITY        0 = none, 1 = odd, 2 = even
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   rx          serial input, asynchronous to clk, idle high
//   uart_data   last good received byte (changes only with uart_valid)
//   uart_valid  1-cycle strobe: new good byte on uart_data
//   frame_err   1-cycle strobe: stop bit sampled low
//   parity_err  1-cycle strobe: parity mismatch with a good stop bit
//   busy        high while a frame is being received (FSM not in IDLE)
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] uart_data,
    output logic       uart_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    // Start bit is sampled mid-bit: the timer starts at 0 in the cycle after
    // the edge was seen, so CLKS_PER_BIT/2 - 1 lands on E + CLKS_PER_BIT/2.
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    // Every later sample is exactly one bit period after the previous one.
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic          ODD       = (PARITY == 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    state_t          state_reg, state_next;
    logic            sync1_reg, sync2_reg;
    logic [TW-1:0]   timer_reg, timer_next;
    logic [2:0]      bit_cnt_reg, bit_cnt_next;
    logic [7:0]      shift_reg, shift_next;
    logic            par_err_reg, par_err_next;
    logic [7:0]      data_reg, data_next;
    logic            valid_reg, valid_next;
    logic            frame_reg, frame_next;
    logic            parity_reg, parity_next;

    logic            rx_s;
    logic            sample_half;
    logic            sample_bit;

    assign rx_s        = sync2_reg;
    assign sample_half = (timer_reg == HALF_LAST);
    assign sample_bit  = (timer_reg == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            sync1_reg   <= 1'b1;
            sync2_reg   <= 1'b1;
            timer_reg   <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            par_err_reg <= 1'b0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            frame_reg   <= 1'b0;
            parity_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sync1_reg   <= rx;
            sync2_reg   <= sync1_reg;
            timer_reg   <= timer_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            par_err_reg <= par_err_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            frame_reg   <= frame_next;
            parity_reg  <= parity_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg + TW'(1);
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        par_err_next = par_err_reg;
        data_next    = data_reg;
        valid_next   = 1'b0;
        frame_next   = 1'b0;
        parity_next  = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                timer_next   = '0;
                bit_cnt_next = '0;
                par_err_next = 1'b0;
                if (!rx_s) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (sample_half) begin
                    timer_next = '0;
                    // A start bit that is high again by mid-bit was a glitch.
                    state_next = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (sample_bit) begin
                    timer_next   = '0;
                    shift_next   = {rx_s, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (sample_bit) begin
                    timer_next   = '0;
                    par_err_next = (rx_s != ((^shift_reg) ^ ODD));
                    state_next   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample_bit) begin
                    timer_next = '0;
                    if (rx_s) begin
                        if (par_err_reg) begin
                            parity_next = 1'b1;
                        end else begin
                            valid_next = 1'b1;
                            data_next  = shift_reg;
                        end
                        state_next = ST_IDLE;
                    end else begin
                        // Framing error wins over any parity mismatch.
                        frame_next = 1'b1;
                        state_next = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // Hold off re-arming until a break / stuck-low line recovers.
                timer_next = '0;
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                timer_next = '0;
            end
        endcase
    end

    assign uart_data  = data_reg;
    assign uart_valid = valid_reg;
    assign frame_err  = frame_reg;
    assign parity_err = parity_reg;
    assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Testbench for uart_byte_rx: one instance without parity (dut0) and one
// with even parity (dut2), CLKS_PER_BIT = 8, directed frames.
module tb_uart_byte_rx;

    localparam int C = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx0 = 1'b1;
    logic       rx2 = 1'b1;

    logic [7:0] u0_data, u2_data;
    logic       u0_valid, u0_frame, u0_parity, u0_busy;
    logic       u2_valid, u2_frame, u2_parity, u2_busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int         v0_cyc[$];
    logic [7:0] v0_dat[$];
    int         v2_cyc[$];
    logic [7:0] v2_dat[$];
    int fe0_cnt = 0, pe0_cnt = 0, fe2_cnt = 0, pe2_cnt = 0;

    uart_byte_rx #(.CLKS_PER_BIT(C), .PARITY(0)) dut0 (
        .clk(clk), .rst(rst), .rx(rx0),
        .uart_data(u0_data), .uart_valid(u0_valid),
        .frame_err(u0_frame), .parity_err(u0_parity), .busy(u0_busy)
    );

    uart_byte_rx #(.CLKS_PER_BIT(C), .PARITY(2)) dut2 (
        .clk(clk), .rst(rst), .rx(rx2),
        .uart_data(u2_data), .uart_valid(u2_valid),
        .frame_err(u2_frame), .parity_err(u2_parity), .busy(u2_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (u0_valid) begin
            v0_cyc.push_back(cyc);
            v0_dat.push_back(u0_data);
        end
        if (u2_valid) begin
            v2_cyc.push_back(cyc);
            v2_dat.push_back(u2_data);
        end
        if (u0_frame)  fe0_cnt++;
        if (u0_parity) pe0_cnt++;
        if (u2_frame)  fe2_cnt++;
        if (u2_parity) pe2_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        v0_cyc.delete(); v0_dat.delete();
        v2_cyc.delete(); v2_dat.delete();
        fe0_cnt = 0; pe0_cnt = 0; fe2_cnt = 0; pe2_cnt = 0;
    endtask

    task automatic set_rx(input bit which, input logic v);
        if (which) rx2 = v;
        else       rx0 = v;
    endtask

    // Sends one frame starting at the current falling edge; s = cyc when the
    // start bit is driven, so the receiver's E is s + 2.
    task automatic send(input bit which, input logic [7:0] d, input bit has_par,
                        input bit par_bit, input bit stop_bit, output int s);
        s = cyc;
        set_rx(which, 1'b0);
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(which, d[i]);
            repeat (C) @(negedge clk);
        end
        if (has_par) begin
            set_rx(which, par_bit);
            repeat (C) @(negedge clk);
        end
        set_rx(which, stop_bit);
        repeat (C) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_assert++;
        if ({u0_data, u0_valid, u0_frame, u0_parity, u0_busy} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_dut0: got %h expected 000", {u0_data, u0_valid, u0_frame, u0_parity, u0_busy});
        end
        n_assert++;
        if ({u2_data, u2_valid, u2_frame, u2_parity, u2_busy} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_dut2: got %h expected 000", {u2_data, u2_valid, u2_frame, u2_parity, u2_busy});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_assert++;
        if (u0_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: got %b expected 0", u0_busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_8n1();
        int s;
        clear_mon();
        send(1'b0, 8'h53, 1'b0, 1'b0, 1'b1, s);
        repeat (10) @(negedge clk);
        n_assert++;
        if (v0_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL 8n1_count: got %0d expected 1", v0_cyc.size());
        end else begin
            n_assert++;
            if (v0_cyc[0] != s + 79) begin
                n_fail++;
                $display("FAIL 8n1_cycle: got %0d expected %0d", v0_cyc[0], s + 79);
            end
            n_assert++;
            if (v0_dat[0] !== 8'h53) begin
                n_fail++;
                $display("FAIL 8n1_data: got %h expected 53", v0_dat[0]);
            end
        end
        n_assert++;
        if (fe0_cnt != 0 || pe0_cnt != 0) begin
            n_fail++;
            $display("FAIL 8n1_errs: got fe=%0d pe=%0d expected 0 0", fe0_cnt, pe0_cnt);
        end
        n_assert++;
        if (u0_data !== 8'h53) begin
            n_fail++;
            $display("FAIL 8n1_hold: got %h expected 53", u0_data);
        end
        $display("test_8n1 sent 0x53 at cycle %0d", s);
    endtask

    task automatic test_glitch();
        int s;
        clear_mon();
        s = cyc;
        rx0 = 1'b0;
        repeat (2) @(negedge clk);
        rx0 = 1'b1;
        @(negedge clk);                       // cyc = E+1
        n_assert++;
        if (u0_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy_hi: got %b expected 1", u0_busy);
        end
        repeat (4) @(negedge clk);            // cyc = E+5
        n_assert++;
        if (u0_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy_lo: got %b expected 0", u0_busy);
        end
        repeat (80) @(negedge clk);
        n_assert++;
        if (v0_cyc.size() != 0 || fe0_cnt != 0 || pe0_cnt != 0) begin
            n_fail++;
            $display("FAIL glitch_strobes: got v=%0d fe=%0d pe=%0d expected 0 0 0", v0_cyc.size(), fe0_cnt, pe0_cnt);
        end
        $display("test_glitch pulse at cycle %0d", s);
    endtask

    task automatic test_frame_err();
        int s;
        clear_mon();
        send(1'b0, 8'h52, 1'b0, 1'b0, 1'b0, s);
        repeat (40) @(negedge clk);
        n_assert++;
        if (fe0_cnt != 1) begin
            n_fail++;
            $display("FAIL frame_count: got %0d expected 1", fe0_cnt);
        end
        n_assert++;
        if (v0_cyc.size() != 0 || pe0_cnt != 0) begin
            n_fail++;
            $display("FAIL frame_other: got v=%0d pe=%0d expected 0 0", v0_cyc.size(), pe0_cnt);
        end
        n_assert++;
        if (u0_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_busy_low_line: got %b expected 1", u0_busy);
        end
        rx0 = 1'b1;
        repeat (5) @(negedge clk);
        n_assert++;
        if (u0_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_busy_recover: got %b expected 0", u0_busy);
        end
        n_assert++;
        if (u0_data !== 8'h53) begin
            n_fail++;
            $display("FAIL frame_data_hold: got %h expected 53", u0_data);
        end
        $display("test_frame_err sent 0x52 with low stop at cycle %0d", s);
    endtask

    task automatic test_parity();
        int s;
        clear_mon();
        send(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, s);
        repeat (10) @(negedge clk);
        n_assert++;
        if (v2_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL par_good1_count: got %0d expected 1", v2_cyc.size());
        end else begin
            n_assert++;
            if (v2_cyc[0] != s + 87 || v2_dat[0] !== 8'hA5) begin
                n_fail++;
                $display("FAIL par_good1: got cyc %0d data %h expected cyc %0d data a5", v2_cyc[0], v2_dat[0], s + 87);
            end
        end
        clear_mon();
        send(1'b1, 8'h53, 1'b1, 1'b1, 1'b1, s);
        repeat (10) @(negedge clk);
        n_assert++;
        if (pe2_cnt != 1 || fe2_cnt != 0 || v2_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL par_bad: got pe=%0d fe=%0d v=%0d expected 1 0 0", pe2_cnt, fe2_cnt, v2_cyc.size());
        end
        n_assert++;
        if (u2_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL par_bad_hold: got %h expected a5", u2_data);
        end
        clear_mon();
        send(1'b1, 8'h53, 1'b1, 1'b0, 1'b1, s);
        repeat (10) @(negedge clk);
        n_assert++;
        if (v2_cyc.size() != 1 || pe2_cnt != 0) begin
            n_fail++;
            $display("FAIL par_good2_count: got v=%0d pe=%0d expected 1 0", v2_cyc.size(), pe2_cnt);
        end else begin
            n_assert++;
            if (v2_dat[0] !== 8'h53) begin
                n_fail++;
                $display("FAIL par_good2_data: got %h expected 53", v2_dat[0]);
            end
        end
        $display("test_parity done");
    endtask

    task automatic test_back_to_back();
        int s1, s2;
        clear_mon();
        send(1'b0, 8'h53, 1'b0, 1'b0, 1'b1, s1);
        send(1'b0, 8'h52, 1'b0, 1'b0, 1'b1, s2);
        repeat (10) @(negedge clk);
        n_assert++;
        if (v0_cyc.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected 2", v0_cyc.size());
        end else begin
            n_assert++;
            if (v0_cyc[0] != s1 + 79 || v0_cyc[1] - v0_cyc[0] != 80) begin
                n_fail++;
                $display("FAIL b2b_timing: got %0d,%0d expected %0d,%0d", v0_cyc[0], v0_cyc[1], s1 + 79, s1 + 159);
            end
            n_assert++;
            if (v0_dat[0] !== 8'h53 || v0_dat[1] !== 8'h52) begin
                n_fail++;
                $display("FAIL b2b_data: got %h,%h expected 53,52", v0_dat[0], v0_dat[1]);
            end
        end
        $display("test_back_to_back frames at cycles %0d and %0d", s1, s2);
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int s;
        d = 8'h3C;
        clear_mon();
        rx0 = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx0 = d[i];
            repeat (C) @(negedge clk);
        end
        rx0 = d[3];
        repeat (C / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_assert++;
        if ({u0_data, u0_valid, u0_frame, u0_parity, u0_busy} !== 12'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h expected 000", {u0_data, u0_valid, u0_frame, u0_parity, u0_busy});
        end
        rst = 1'b0;
        rx0 = 1'b1;
        repeat (60) @(negedge clk);
        n_assert++;
        if (v0_cyc.size() != 0 || fe0_cnt != 0 || pe0_cnt != 0 || u0_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_abort: got v=%0d fe=%0d pe=%0d busy=%b expected 0 0 0 0", v0_cyc.size(), fe0_cnt, pe0_cnt, u0_busy);
        end
        clear_mon();
        send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, s);
        repeat (10) @(negedge clk);
        n_assert++;
        if (v0_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL midrst_next_count: got %0d expected 1", v0_cyc.size());
        end else begin
            n_assert++;
            if (v0_dat[0] !== 8'hA5) begin
                n_fail++;
                $display("FAIL midrst_next_data: got %h expected a5", v0_dat[0]);
            end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_glitch();
        test_frame_err();
        test_parity();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
